multihot_serial_encoder: RTL and testbench
==========================================

// Module: multihot_serial_encoder
// PURPOSE
//  Parametrised, sequential successor to the fixed 8-to-3 one-hot encoder.
//  Accepts an N-bit multi-hot request vector over a valid/ready handshake.
//  Emits the binary index of every set bit, one index per accepted output beat.
//  Sits between request/interrupt sources and a downstream serial consumer.
// PARAMETERS
//  N          8   number of request lines; must be >= 2
//  MSB_FIRST  0   0: emit lowest set index first; 1: emit highest first
//  W          $clog2(N)   localparam, index width (3 for N=8)
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   asynchronous reset, active-high
//  in_valid   in   1   in_vec is valid
//  in_ready   out  1   block can accept a vector (high only in IDLE)
//  in_vec     in   N   multi-hot request vector
//  out_valid  out  1   out_idx is valid
//  out_ready  in   1   consumer accepts out_idx this cycle
//  out_idx    out  W   binary index of the current selected bit
//  out_last   out  1   current beat is the final index of the vector
//  zero_err   out  1   one-cycle pulse: an all-zero vector was accepted
//  busy       out  1   vector held, indices still pending (== state EMIT)
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, pend=0, out_valid=0, out_idx=0,
//    out_last=0, zero_err=0, busy=0, in_ready=1 once rst deasserts.
//  - States: IDLE, EMIT. Register pend[N-1:0] holds the remaining bits.
//  - IDLE: in_ready=1. On in_valid&in_ready at edge:
//      in_vec==0 -> zero_err=1 for the next cycle only, stay IDLE;
//      else pend<=in_vec, go EMIT. Latency accept -> out_valid: 1 cycle.
//  - EMIT: in_ready=0, out_valid=1. out_idx = index of lowest (MSB_FIRST=0)
//    or highest (MSB_FIRST=1) set bit of pend; combinational from pend.
//    out_last=1 iff pend has exactly one bit set.
//  - Output fire = out_valid & out_ready: clear selected bit in pend;
//    if out_last, go IDLE (in_ready=1 next cycle). No fire -> out_idx,
//    out_last, pend held stable (AXI-style; valid never drops unfired).
//  - Beats per vector = popcount(in_vec); no bubble between beats when
//    out_ready held high. Vector of 1 bit = single beat with out_last=1.
//  - in_valid during EMIT ignored (no capture, no error); source must hold.
//  - in_vec sampled only at accept; later changes have no effect.
//  - rst asserted mid-EMIT: pending indices discarded, no further beats.
//  - X/Z on in_vec is out of scope; bench drives only known values.
// STRUCTURE
//  - Shared header enc_defs.vh: state encodings ST_IDLE=1'b0, ST_EMIT=1'b1.
//  - One sub-module: prio_enc #(N, MSB_FIRST) -- combinational, pend ->
//    {idx[W-1:0], any}; also reused by other encoder blocks.
//  - Top holds FSM, pend register, zero_err pulse, one-hot clear mask.
// TESTING
//  1 Reset: assert rst mid-cycle -> all outputs 0 immediately; in_ready=1
//    after release.
//  2 One-hot sweep N=8: in_vec=8'h01..8'h80, out_ready=1 -> single beat
//    each, out_idx=0..7, out_last=1.
//  3 Multi-hot 8'b1010_0110, MSB_FIRST=0, out_ready=1 -> idx 1,2,5,7 on
//    consecutive cycles, out_last only on 7; MSB_FIRST=1 -> 7,5,2,1.
//  4 Backpressure: same vector, out_ready low 3 cycles on beat 2 ->
//    out_idx=2 held stable, out_valid=1, no beat lost or repeated.
//  5 Zero vector 8'h00 accepted -> zero_err=1 exactly one cycle,
//    out_valid stays 0, in_ready stays 1.
//  6 rst after first beat of 8'hFF -> no more beats; new vector 8'h10
//    after release -> single beat out_idx=4; repeat at N=16 with 16'h8001
//    -> idx 0 then 15.

Source files
------------

// File: rtl/multihot_serial_encoder_pkg.sv
// Shared types for the multi-hot serial encoder: FSM state encoding.
package multihot_serial_encoder_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/multihot_serial_encoder_prio_enc.sv
// Combinational priority encoder: index of the lowest (or highest) set bit of pend.
module prio_enc #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b0,
    localparam int W        = $clog2(N)
) (
    input  logic [N-1:0] pend,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan so that the winning bit is the last one to overwrite idx.
    always_comb begin
        idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i]) idx = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (pend[i]) idx = W'(i);
            end
        end
    end

    assign any = |pend;

endmodule

// File: rtl/multihot_serial_encoder.sv
// Accepts a multi-hot vector and streams the index of each set bit, one per output beat.
module multihot_serial_encoder
    import multihot_serial_encoder_pkg::*;
#(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b0,
    localparam int W        = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         zero_err,
    output logic         busy
);

    state_t       state_reg;
    logic [N-1:0] pend_reg;
    logic [N-1:0] clear_mask;
    logic [W-1:0] sel_idx;
    logic         sel_any;
    logic         single;

    prio_enc #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_prio (
        .pend (pend_reg),
        .idx  (sel_idx),
        .any  (sel_any)
    );

    // Exactly one bit left: clearing the lowest set bit leaves nothing.
    assign single     = sel_any && ((pend_reg & (pend_reg - N'(1))) == '0);
    assign clear_mask = N'(1) << sel_idx;

    assign out_valid = (state_reg == ST_EMIT);
    assign busy      = (state_reg == ST_EMIT);
    assign out_idx   = sel_idx;
    assign out_last  = out_valid && single;
    assign in_ready  = (state_reg == ST_IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            pend_reg  <= '0;
            zero_err  <= 1'b0;
        end else begin
            zero_err <= 1'b0;
            if (state_reg == ST_IDLE) begin
                if (in_valid) begin
                    if (in_vec == '0) begin
                        zero_err <= 1'b1;
                    end else begin
                        pend_reg  <= in_vec;
                        state_reg <= ST_EMIT;
                    end
                end
            end else begin
                if (out_ready) begin
                    pend_reg <= pend_reg & ~clear_mask;
                    if (single) state_reg <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_multihot_serial_encoder.sv
// Bench: lockstep LSB-first and MSB-first N=8 encoders against a queue model, plus an N=16 instance.
module tb_multihot_serial_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_vec;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, out_last_a, zero_err_a, busy_a;
    logic [2:0] out_idx_a;
    logic       in_ready_b, out_valid_b, out_last_b, zero_err_b, busy_b;
    logic [2:0] out_idx_b;

    logic        in_valid2, out_ready2;
    logic [15:0] in_vec2;
    logic        in_ready_c, out_valid_c, out_last_c, zero_err_c, busy_c;
    logic [3:0]  out_idx_c;

    always #5 clk = ~clk;

    multihot_serial_encoder #(.N(8), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_vec(in_vec),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_idx(out_idx_a),
        .out_last(out_last_a), .zero_err(zero_err_a), .busy(busy_a));

    multihot_serial_encoder #(.N(8), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_vec(in_vec),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_idx(out_idx_b),
        .out_last(out_last_b), .zero_err(zero_err_b), .busy(busy_b));

    multihot_serial_encoder #(.N(16), .MSB_FIRST(1'b0)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready_c), .in_vec(in_vec2),
        .out_valid(out_valid_c), .out_ready(out_ready2), .out_idx(out_idx_c),
        .out_last(out_last_c), .zero_err(zero_err_c), .busy(busy_c));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: remaining set indices in ascending order. LSB-first consumes the front,
    // MSB-first consumes the back; both see the same beat count, so they run in lockstep.
    int q_lo[$];
    int q_hi[$];
    bit m_active = 1'b0;
    bit m_zero   = 1'b0;
    bit acc_flag = 1'b0;

    int log_a_idx[$];
    int log_a_last[$];
    int log_a_cyc[$];
    int log_b_idx[$];
    int log_c_idx[$];
    int log_c_last[$];

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("rst.a.out_valid", int'(out_valid_a), 0);
            chk("rst.a.out_idx",   int'(out_idx_a), 0);
            chk("rst.a.zero_err",  int'(zero_err_a), 0);
            chk("rst.a.in_ready",  int'(in_ready_a), 0);
            chk("rst.b.out_valid", int'(out_valid_b), 0);
            chk("rst.b.busy",      int'(busy_b), 0);
            q_lo.delete();
            q_hi.delete();
            m_active = 1'b0;
            m_zero   = 1'b0;
            acc_flag = 1'b0;
        end else begin
            chk("a.out_valid", int'(out_valid_a), int'(m_active));
            chk("b.out_valid", int'(out_valid_b), int'(m_active));
            chk("a.in_ready",  int'(in_ready_a), int'(!m_active));
            chk("b.in_ready",  int'(in_ready_b), int'(!m_active));
            chk("a.busy",      int'(busy_a), int'(m_active));
            chk("a.zero_err",  int'(zero_err_a), int'(m_zero));
            chk("b.zero_err",  int'(zero_err_b), int'(m_zero));
            if (m_active) begin
                chk("a.out_idx",  int'(out_idx_a), q_lo[0]);
                chk("b.out_idx",  int'(out_idx_b), q_hi[$]);
                chk("a.out_last", int'(out_last_a), int'(q_lo.size() == 1));
                chk("b.out_last", int'(out_last_b), int'(q_hi.size() == 1));
            end else begin
                chk("a.out_last", int'(out_last_a), 0);
            end
            if (out_valid_a && out_ready) begin
                log_a_idx.push_back(int'(out_idx_a));
                log_a_last.push_back(int'(out_last_a));
                log_a_cyc.push_back(cyc);
            end
            if (out_valid_b && out_ready) log_b_idx.push_back(int'(out_idx_b));
            // Advance the model by the handshakes the coming edge will see.
            m_zero   = 1'b0;
            acc_flag = 1'b0;
            if (!m_active) begin
                if (in_valid) begin
                    acc_flag = 1'b1;
                    if (in_vec == 8'h00) begin
                        m_zero = 1'b1;
                    end else begin
                        for (int i = 0; i < 8; i++) begin
                            if (in_vec[i]) begin
                                q_lo.push_back(i);
                                q_hi.push_back(i);
                            end
                        end
                        m_active = 1'b1;
                    end
                end
            end else if (out_ready) begin
                void'(q_lo.pop_front());
                void'(q_hi.pop_back());
                if (q_lo.size() == 0) m_active = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid_c && out_ready2) begin
            log_c_idx.push_back(int'(out_idx_c));
            log_c_last.push_back(int'(out_last_c));
        end
    end

    task automatic clear_logs();
        log_a_idx.delete(); log_a_last.delete(); log_a_cyc.delete();
        log_b_idx.delete(); log_c_idx.delete(); log_c_last.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        int n = 0;
        in_valid = 1'b1;
        in_vec   = v;
        do begin
            step();
            n++;
        end while (!acc_flag && n < 50);
        if (!acc_flag) begin
            checks++;
            errors++;
            $display("FAIL send.timeout actual=no_accept required=accept vec=%02h", v);
        end
        in_valid = 1'b0;
        in_vec   = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_active && n < 200) begin
            step();
            n++;
        end
        if (m_active) begin
            checks++;
            errors++;
            $display("FAIL wait_idle.timeout actual=busy required=idle");
        end
        step();
    endtask

    task automatic expect_log(input string name, input int exp_a[$], input int exp_b[$]);
        chk({name, ".beats"}, log_a_idx.size(), exp_a.size());
        chk({name, ".beats_b"}, log_b_idx.size(), exp_b.size());
        for (int i = 0; i < exp_a.size() && i < log_a_idx.size(); i++) begin
            chk({name, ".idx_a"}, log_a_idx[i], exp_a[i]);
            chk({name, ".last_a"}, log_a_last[i], int'(i == exp_a.size() - 1));
        end
        for (int i = 0; i < exp_b.size() && i < log_b_idx.size(); i++)
            chk({name, ".idx_b"}, log_b_idx[i], exp_b[i]);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_vec = 8'h00; out_ready = 1'b0;
        in_valid2 = 1'b0; in_vec2 = 16'h0000; out_ready2 = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        chk("reset.in_ready_after_release", int'(in_ready_a), 1);
        chk("reset.out_valid", int'(out_valid_a), 0);

        // One-hot sweep
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            clear_logs();
            send(8'(1 << i));
            wait_idle();
            expect_log("onehot", '{i}, '{i});
        end

        // Multi-hot, both orders, no bubbles
        clear_logs();
        send(8'b1010_0110);
        wait_idle();
        expect_log("multihot", '{1, 2, 5, 7}, '{7, 5, 2, 1});
        if (log_a_cyc.size() == 4)
            chk("multihot.no_bubble", log_a_cyc[3] - log_a_cyc[0], 3);

        // Backpressure on the second beat
        clear_logs();
        send(8'b1010_0110);
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("bp.out_idx_held", int'(out_idx_a), 2);
            chk("bp.out_valid_held", int'(out_valid_a), 1);
            step();
        end
        out_ready = 1'b1;
        wait_idle();
        expect_log("backpressure", '{1, 2, 5, 7}, '{7, 5, 2, 1});

        // Zero vector
        send(8'h00);
        chk("zero.zero_err", int'(zero_err_a), 1);
        chk("zero.out_valid", int'(out_valid_a), 0);
        chk("zero.in_ready", int'(in_ready_a), 1);
        step();
        chk("zero.zero_err_cleared", int'(zero_err_a), 0);

        // Reset mid-EMIT
        clear_logs();
        send(8'hFF);
        step();
        #2 rst = 1'b1;
        #1;
        chk("midrst.out_valid", int'(out_valid_a), 0);
        chk("midrst.busy", int'(busy_a), 0);
        chk("midrst.in_ready", int'(in_ready_a), 0);
        chk("midrst.beats_before", log_a_idx.size(), 1);
        step();
        rst = 1'b0;
        clear_logs();
        step(); step();
        chk("midrst.no_more_beats", log_a_idx.size(), 0);
        send(8'h10);
        wait_idle();
        expect_log("after_rst", '{4}, '{4});

        // N=16 instance
        in_valid2 = 1'b1;
        in_vec2   = 16'h8001;
        step();
        in_valid2 = 1'b0;
        for (int n = 0; n < 20 && log_c_idx.size() < 2; n++) step();
        chk("n16.beats", log_c_idx.size(), 2);
        if (log_c_idx.size() == 2) begin
            chk("n16.idx0", log_c_idx[0], 0);
            chk("n16.last0", log_c_last[0], 0);
            chk("n16.idx1", log_c_idx[1], 15);
            chk("n16.last1", log_c_last[1], 1);
        end
        step();
        chk("n16.idle_ready", int'(in_ready_c), 1);

        // Randomized traffic with occasional resets and in_vec churn during EMIT
        for (int n = 0; n < 3000; n++) begin
            step();
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                continue;
            end
            rst       = 1'b0;
            in_valid  = 1'($urandom_range(0, 1));
            in_vec    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
